// File: rtl/scalar_product_feeder_if.sv
// Stream and MAC-side signal bundle for scalar_product_feeder.
// The master modport is the feeder's view; the slave modport is the source/MAC/sink view.
interface scalar_product_feeder_if #(
   parameter int Nbits = 4,
   parameter int Ndata = 4
);
   logic                     in_valid;
   logic [Nbits-1:0]         in_a;
   logic [Nbits-1:0]         in_b;
   logic                     in_ready;
   logic [Ndata*Nbits-1:0]   A;
   logic [Ndata*Nbits-1:0]   B;
   logic                     mac_reset;
   logic [2*Nbits-1:0]       mac_out;
   logic                     res_valid;
   logic [2*Nbits-1:0]       res_data;
   logic                     res_ready;

   modport master (
      input  in_valid, in_a, in_b, mac_out, res_ready,
      output in_ready, A, B, mac_reset, res_valid, res_data
   );

   modport slave (
      output in_valid, in_a, in_b, mac_out, res_ready,
      input  in_ready, A, B, mac_reset, res_valid, res_data
   );
endinterface

// File: rtl/scalar_product_feeder.sv
// Packs serial operand pairs into the MAC's A/B vectors, runs the MAC for a
// fixed window, then holds the captured result on a valid/ready port.
module scalar_product_feeder #(
   parameter int Nbits     = 4,
   parameter int Ndata     = 4,
   parameter int MacCycles = Ndata + 2
) (
   input  logic clk,
   input  logic reset,
   scalar_product_feeder_if.master bus
);
   localparam int IW = (Ndata > 1) ? $clog2(Ndata) : 1;
   localparam int CW = (MacCycles > 1) ? $clog2(MacCycles) : 1;

   typedef enum logic [1:0] {LOAD, RUN, RESULT} state_t;

   state_t                 state;
   logic [IW-1:0]          idx;
   logic [CW-1:0]          cnt;
   logic [Ndata*Nbits-1:0] a_q;
   logic [Ndata*Nbits-1:0] b_q;
   logic [2*Nbits-1:0]     res_q;
   logic                   in_ready_q;
   logic                   mac_reset_q;
   logic                   res_valid_q;

   // Handshake outputs are registered alongside the state so no input reaches them combinationally.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every register here uses <= so all reads within one edge see pre-edge values.
      if (reset) begin
         state       <= LOAD;
         idx         <= '0;
         cnt         <= '0;
         // NOTE: the operand vectors are plain flops, so clearing them on reset is cheap and keeps A/B defined for the MAC.
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         mac_reset_q <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (bus.in_valid && in_ready_q) begin
                  a_q[int'(idx)*Nbits +: Nbits] <= bus.in_a;
                  b_q[int'(idx)*Nbits +: Nbits] <= bus.in_b;
                  if (idx == IW'(Ndata - 1)) begin
                     idx         <= '0;
                     cnt         <= '0;
                     state       <= RUN;
                     in_ready_q  <= 1'b0;
                     mac_reset_q <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            RUN: begin
               if (cnt == CW'(MacCycles - 1)) begin
                  res_q       <= bus.mac_out;
                  cnt         <= '0;
                  state       <= RESULT;
                  mac_reset_q <= 1'b1;
                  res_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESULT: begin
               if (bus.res_ready && res_valid_q) begin
                  state       <= LOAD;
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= LOAD;
               idx         <= '0;
               cnt         <= '0;
               in_ready_q  <= 1'b1;
               mac_reset_q <= 1'b1;
               res_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.res_data  = res_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.mac_reset = mac_reset_q;
   assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_scalar_product_feeder.sv
// Directed bench for scalar_product_feeder with a small behavioural MAC attached.
// Each comparison is an immediate assertion; a summary line closes the run.
module tb_scalar_product_feeder;
   logic clk = 1'b0;
   logic reset;

   int n_cmp  = 0;
   int n_fail = 0;

   scalar_product_feeder_if #(.Nbits(4), .Ndata(4)) bus ();

   scalar_product_feeder #(.Nbits(4), .Ndata(4), .MacCycles(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Behavioural MAC: cleared while mac_reset is high, then adds one product per cycle.
   logic [7:0] acc = '0;
   int         k   = 0;
   always @(posedge clk) begin
      if (bus.mac_reset) begin
         acc <= '0;
         k   <= 0;
      end else if (k < 4) begin
         acc <= acc + 8'(bus.A[k*4 +: 4]) * 8'(bus.B[k*4 +: 4]);
         k   <= k + 1;
      end
   end
   assign bus.mac_out = acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      step();
   endtask

   task automatic wait_result(input string tag);
      int g = 0;
      while (!bus.res_valid && g < 50) begin
         step();
         g++;
      end
      check(tag, 32'(bus.res_valid), 32'd1);
   endtask

   task automatic handshake();
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
   endtask

   task automatic async_reset_pulse();
      #2;
      reset = 1'b1;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, "_mac_reset"}, 32'(bus.mac_reset), 32'd1);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      check({tag, "_A"},         32'(bus.A),         32'd0);
      check({tag, "_B"},         32'(bus.B),         32'd0);
   endtask

   initial begin
      int low_cycles;
      logic [3:0] pa [8];
      logic [3:0] pb [8];
      int p, nres, t_res0, t_res1;
      logic [7:0] r0, r1;
      logic prev_rv;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.res_ready = 1'b0;

      // Reset state
      #2;
      check_reset_state("rst");
      check("rst_res_data", 32'(bus.res_data), 32'd0);
      release_reset();

      // Basic product
      send(4'd1, 4'd6);
      send(4'd2, 4'd5);
      send(4'd3, 4'd4);
      send(4'd2, 4'd1);
      bus.in_valid = 1'b0;
      check("basic_A", 32'(bus.A), 32'h2321);
      check("basic_B", 32'(bus.B), 32'h1456);
      check("basic_in_ready_run", 32'(bus.in_ready), 32'd0);
      low_cycles = 0;
      while (!bus.mac_reset && low_cycles < 50) begin
         low_cycles++;
         step();
      end
      check("basic_mac_reset_low_cycles", 32'(low_cycles), 32'd6);
      check("basic_res_valid", 32'(bus.res_valid), 32'd1);
      check("basic_res_data", 32'(bus.res_data), 32'h1E);
      handshake();
      check("basic_back_to_load", 32'(bus.in_ready), 32'd1);
      check("basic_res_valid_drop", 32'(bus.res_valid), 32'd0);

      // Wrap-around
      send(4'd15, 4'd15);
      send(4'd15, 4'd15);
      send(4'd15, 4'd15);
      send(4'd1, 4'd1);
      bus.in_valid = 1'b0;
      check("wrap_A", 32'(bus.A), 32'h1FFF);
      wait_result("wrap_wait");
      check("wrap_res_data", 32'(bus.res_data), 32'd164);
      handshake();

      // Source stall between 2nd and 3rd pair
      send(4'd1, 4'd6);
      send(4'd2, 4'd5);
      bus.in_valid = 1'b0;
      bus.in_a     = 4'd7;
      bus.in_b     = 4'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_in_ready", 32'(bus.in_ready), 32'd1);
         check("stall_mac_reset", 32'(bus.mac_reset), 32'd1);
         check("stall_A", 32'(bus.A), 32'h1F21);
         check("stall_B", 32'(bus.B), 32'h1F56);
      end
      send(4'd3, 4'd4);
      check("stall_still_load", 32'(bus.mac_reset), 32'd1);
      send(4'd2, 4'd1);
      bus.in_valid = 1'b0;
      check("stall_run_started", 32'(bus.mac_reset), 32'd0);
      wait_result("stall_wait");
      check("stall_res_data", 32'(bus.res_data), 32'h1E);

      // Sink backpressure with a pending (9,9) pair
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd9;
      bus.in_b     = 4'd9;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_res_valid", 32'(bus.res_valid), 32'd1);
         check("bp_res_data", 32'(bus.res_data), 32'h1E);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_A", 32'(bus.A), 32'h2321);
         check("bp_B", 32'(bus.B), 32'h1456);
      end
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_release_A", 32'(bus.A), 32'h2321);
      step();
      check("bp_accept_A", 32'(bus.A), 32'h2329);
      check("bp_accept_B", 32'(bus.B), 32'h1459);

      // Reset after 2 of 4 loads
      send(4'd9, 4'd9);
      bus.in_valid = 1'b0;
      check("part_A", 32'(bus.A), 32'h2399);
      async_reset_pulse();
      check_reset_state("part_rst");
      release_reset();
      send(4'd1, 4'd6);
      send(4'd2, 4'd5);
      send(4'd3, 4'd4);
      send(4'd2, 4'd1);
      bus.in_valid = 1'b0;
      check("part_reload_A", 32'(bus.A), 32'h2321);
      wait_result("part_wait");
      check("part_res_data", 32'(bus.res_data), 32'h1E);
      handshake();

      // Reset in RUN at cnt=2
      send(4'd1, 4'd6);
      send(4'd2, 4'd5);
      send(4'd3, 4'd4);
      send(4'd2, 4'd1);
      bus.in_valid = 1'b0;
      step();
      step();
      check("run_rst_pre_mac_reset", 32'(bus.mac_reset), 32'd0);
      async_reset_pulse();
      check_reset_state("run_rst");
      release_reset();
      for (int i = 0; i < 8; i++) step();
      check("run_rst_no_stale_result", 32'(bus.res_valid), 32'd0);
      send(4'd15, 4'd15);
      send(4'd15, 4'd15);
      send(4'd15, 4'd15);
      send(4'd1, 4'd1);
      bus.in_valid = 1'b0;
      wait_result("run_rst_wait");
      check("run_rst_res_data", 32'(bus.res_data), 32'd164);
      handshake();

      // Back-to-back with source and sink always ready
      pa = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd15, 4'd15, 4'd15, 4'd1};
      pb = '{4'd6, 4'd5, 4'd4, 4'd1, 4'd15, 4'd15, 4'd15, 4'd1};
      p = 0; nres = 0; t_res0 = 0; t_res1 = 0; r0 = '0; r1 = '0; prev_rv = 1'b0;
      bus.res_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (prev_rv) check("b2b_in_ready_after_res", 32'(bus.in_ready), 32'd1);
         if (bus.res_valid && nres == 0) begin
            r0 = bus.res_data; t_res0 = c; nres = 1;
         end else if (bus.res_valid && nres == 1) begin
            r1 = bus.res_data; t_res1 = c; nres = 2;
         end
         prev_rv = bus.res_valid;
         if (bus.in_ready && p < 8) begin
            bus.in_valid = 1'b1;
            bus.in_a     = pa[p];
            bus.in_b     = pb[p];
            p++;
         end else if (p >= 8) begin
            bus.in_valid = 1'b0;
         end
         step();
      end
      bus.res_ready = 1'b0;
      check("b2b_result_count", 32'(nres), 32'd2);
      check("b2b_res0", 32'(r0), 32'h1E);
      check("b2b_res1", 32'(r1), 32'd164);
      check("b2b_period", 32'(t_res1 - t_res0), 32'd11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/scalar_product_feeder.md
# scalar_product_feeder

Initiator-side sequencer for `scalar_product_mac`. It accepts operand pairs one element at a time over a valid/ready stream and packs them into the `A`/`B` vectors the MAC consumes. It then releases the MAC reset for a fixed compute window, captures the MAC result and presents it on a valid/ready result port. It sits between a serial data source (memory reader, UART front end) and the MAC.

## Interface
- `Nbits`, 4, width of one operand element.
- `Ndata`, 4, number of element pairs per scalar product.
- `MacCycles`, `Ndata`+2, number of cycles `mac_reset` is held low before the MAC output is sampled; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  operand pair on `in_a`/`in_b` is valid.
- `in_a`  in  `Nbits`  operand element for vector A.
- `in_b`  in  `Nbits`  operand element for vector B.
- `in_ready`  out  1  feeder accepts an operand pair this cycle.
- `A`  out  `Ndata*Nbits`  packed vector A to the MAC; element i in bits [i*Nbits +: Nbits].
- `B`  out  `Ndata*Nbits`  packed vector B to the MAC; same packing as `A`.
- `mac_reset`  out  1  reset to the MAC; active-high.
- `mac_out`  in  `2*Nbits`  MAC result.
- `res_valid`  out  1  `res_data` holds a captured result.
- `res_data`  out  `2*Nbits`  captured scalar product.
- `res_ready`  in  1  consumer accepts the result.

## Operation
- The FSM has three states: LOAD, RUN and RESULT.
- Element index register `idx` is 0..`Ndata`-1. Cycle counter `cnt` is 0..`MacCycles`-1.
- **LOAD**
  - `in_ready`=1, `mac_reset`=1, `res_valid`=0.
  - On `in_valid`&`in_ready`: element `idx` of `A` ← `in_a`, element `idx` of `B` ← `in_b`.
  - If `idx`=`Ndata`-1: `idx` ← 0, `cnt` ← 0, go to RUN. Otherwise `idx` ← `idx`+1.
  - `in_valid`=0 holds state and `idx`.
- **RUN**
  - `in_ready`=0, `mac_reset`=0.
  - `cnt` increments each cycle.
  - On the edge where `cnt`=`MacCycles`-1: `res_data` ← `mac_out`, go to RESULT.
- **RESULT**
  - `res_valid`=1, `mac_reset`=1, `in_ready`=0.
  - On `res_valid`&`res_ready`: go to LOAD.
  - `res_data` is stable while `res_valid`=1.
- `A`/`B` are never cleared between products. Stale elements are simply overwritten by the next load.
- Arithmetic and overflow are the MAC's responsibility. The feeder copies `mac_out` unmodified (modulo 2^(2*`Nbits`) as produced).
- `in_valid` outside LOAD is ignored and no data is captured. `res_ready` outside RESULT is ignored.
- Asserting `reset` in any state returns to LOAD at once and discards the partial load, any in-flight product and any pending result.

## Timing
- Reset values:
  - state=LOAD, `idx`=0, `cnt`=0.
  - `A`=0, `B`=0, `res_data`=0.
  - `res_valid`=0, `mac_reset`=1, `in_ready`=1.
- `in_ready`, `mac_reset` and `res_valid` are decoded from the registered state only. There is no combinational path from any input.
- Minimum load time is `Ndata` cycles, achieved with `in_valid` held high.
- `mac_reset` is low for exactly `MacCycles` consecutive cycles, starting the cycle after the last accepted pair.
- `res_valid` rises the cycle after the last RUN cycle.
- With the consumer always ready, `in_ready` returns 1 the cycle after `res_valid` rises.
- Throughput with source and sink always ready is one product per `Ndata`+`MacCycles`+1 cycles.

## Test plan
- **Basic product:**
  - Stimulus: after reset, stream pairs (a,b) = (1,6),(2,5),(3,4),(2,1) with `in_valid` held high; the MAC is attached.
  - Required: `A`=16'h2321, `B`=16'h1456; `mac_reset` low for 6 cycles; `res_valid`=1 with `res_data`=30 (8'h1E).
- **Wrap-around:**
  - Stimulus: pairs (15,15)×3 then (1,1).
  - Required: `res_data`=164 (676 mod 256).
- **Source stall:**
  - Stimulus: same data as the basic product, with `in_valid` low for 3 cycles between the 2nd and 3rd pair.
  - Required: `idx` holds; result still 30; RUN starts only after the 4th accept.
- **Sink backpressure:**
  - Stimulus: hold `res_ready`=0 for 10 cycles in RESULT, and drive `in_valid`=1 with data (9,9).
  - Required: `res_valid` and `res_data` stable; `in_ready`=0; no element overwritten; the (9,9) pair is accepted only after the `res_ready` handshake and the return to LOAD.
- **Reset mid-operation:**
  - Stimulus: assert `reset` asynchronously in RUN (cnt=2), and separately after 2 of 4 loads.
  - Required: immediately `mac_reset`=1, `res_valid`=0, `A`=`B`=0, `in_ready`=1; a following full load produces the correct result.
- **Back-to-back:**
  - Stimulus: two products with source and sink always ready.
  - Required: results 30 then 164; `in_ready` re-asserts the cycle after `res_valid`; 11-cycle period.
